// File: rtl/tdm_mux_8to1_pkg.sv
// Types and constants shared by the TDM serializer and the matching 1-to-8 demux.
package tdm_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } tdm_state_t;

  localparam int TDM_LANES = 8;
  localparam int TDM_SEL_W = 3;

endpackage

// File: rtl/tdm_mux_8to1_if.sv
// Frame-in / beat-out handshake bundle for the TDM serializer.
interface tdm_mux_8to1_if
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int LANES = TDM_LANES,
  parameter int SEL_W = $clog2(LANES)
);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [SEL_W-1:0]       out_sel;
  logic                   out_sof;

  // master: frame producer and beat consumer; slave: the serializer
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_sof
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_sof
  );

endinterface

// File: rtl/tdm_mux_8to1_lane_counter.sv
// Lane index counter: clear-to-zero has priority over increment; last flags LANES-1.
module tdm_lane_counter
  import tdm_pkg::*;
#(
  parameter int LANES = TDM_LANES,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             load0_i,
  output logic [SEL_W-1:0] count_o,
  output logic             last_o
);

  logic [SEL_W-1:0] count_q;
  logic [SEL_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load0_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == SEL_W'(LANES - 1));

endmodule

// File: rtl/tdm_mux_8to1.sv
// TDM serializer: takes one LANES-wide frame per handshake and emits it lane by lane.
module tdm_mux_8to1
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int LANES = TDM_LANES
) (
  input  logic           clk,
  input  logic           rst,
  tdm_mux_8to1_if.slave  bus
);

  localparam int SEL_W = $clog2(LANES);

  tdm_state_t             state_q, state_d;
  logic [LANES*WIDTH-1:0] frame_q, frame_d;
  logic                   cnt_inc;
  logic                   cnt_load0;
  logic                   cnt_last;
  logic [SEL_W-1:0]       cnt;
  logic                   in_ready_c;
  logic [WIDTH-1:0]       lane_w [LANES];

  tdm_lane_counter #(
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (cnt_inc),
    .load0_i (cnt_load0),
    .count_o (cnt),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    cnt_inc    = 1'b0;
    cnt_load0  = 1'b0;
    in_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          frame_d   = bus.in_data;
          state_d   = SEND;
          cnt_load0 = 1'b1;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (!cnt_last) begin
            cnt_inc = 1'b1;
          end else begin
            // Final beat doubles as an accept slot so frames can run back to back.
            in_ready_c = 1'b1;
            cnt_load0  = 1'b1;
            if (bus.in_valid) begin
              frame_d = bus.in_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_w[k] = frame_q[k*WIDTH +: WIDTH];
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_sel   = cnt;
  assign bus.out_data  = (state_q == SEND) ? lane_w[cnt] : '0;
  assign bus.out_sof   = (state_q == SEND) && (cnt == '0);

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Directed bench for the TDM serializer with a behavioural demux capture.
module tb_tdm_mux_8to1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tdm_mux_8to1_if #(.WIDTH(1), .LANES(8)) bus ();

  tdm_mux_8to1 #(.WIDTH(1), .LANES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", bus.out_sel); end
    checks++; if (bus.out_data !== 1'b0) begin errors++; $display("FAIL reset_data: got %b want 0", bus.out_data); end
    checks++; if (bus.out_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b want 0", bus.out_sof); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] f;
    f = 8'b1010_0110;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = f;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_accept_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b want 1", k, bus.out_valid); end
      checks++; if (bus.out_sel !== 3'(k)) begin errors++; $display("FAIL single_sel[%0d]: got %0d want %0d", k, bus.out_sel, k); end
      checks++; if (bus.out_data !== f[k]) begin errors++; $display("FAIL single_data[%0d]: got %b want %b", k, bus.out_data, f[k]); end
      checks++; if (bus.out_sof !== (k == 0)) begin errors++; $display("FAIL single_sof[%0d]: got %b want %b", k, bus.out_sof, (k == 0)); end
      checks++; if (bus.in_ready !== (k == 7)) begin errors++; $display("FAIL single_ready[%0d]: got %b want %b", k, bus.in_ready, (k == 7)); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_sel !== 3'd0) begin errors++; $display("FAIL single_idle_sel: got %0d want 0", bus.out_sel); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept_a: got %b want 1", bus.in_ready); end
    tick();
    bus.in_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      exp_d = (i < 8);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.out_valid); end
      checks++; if (bus.out_sel !== 3'(i % 8)) begin errors++; $display("FAIL b2b_sel[%0d]: got %0d want %0d", i, bus.out_sel, i % 8); end
      checks++; if (bus.out_data !== exp_d) begin errors++; $display("FAIL b2b_data[%0d]: got %b want %b", i, bus.out_data, exp_d); end
      checks++; if (bus.in_ready !== (i % 8 == 7)) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, bus.in_ready, (i % 8 == 7)); end
      tick();
      if (i == 7) begin
        // new in_data while busy must not disturb frame B
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h5A;
      end
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] f;
    f = 8'hC3;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = f;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.out_sel !== 3'(k) || bus.out_data !== f[k] || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_beat[%0d]: got sel=%0d data=%b valid=%b want sel=%0d data=%b valid=1",
                           k, bus.out_sel, bus.out_data, bus.out_valid, k, f[k]);
      end
      if (k == 3) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          checks++; if (bus.out_sel !== 3'd3 || bus.out_data !== f[3] || bus.out_valid !== 1'b1 || bus.out_sof !== 1'b0) begin
            errors++; $display("FAIL bp_hold[%0d]: got sel=%0d data=%b valid=%b sof=%b want sel=3 data=%b valid=1 sof=0",
                               s, bus.out_sel, bus.out_data, bus.out_valid, bus.out_sof, f[3]);
          end
          checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", s, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
      end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    checks++; if (bus.out_sel !== 3'd5 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL mrst_pre: got sel=%0d valid=%b want sel=5 valid=1", bus.out_sel, bus.out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_sel !== 3'd0) begin errors++; $display("FAIL mrst_sel: got %0d want 0", bus.out_sel); end
    checks++; if (bus.out_data !== 1'b0) begin errors++; $display("FAIL mrst_data: got %b want 0", bus.out_data); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_after_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mrst_after_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_round_trip();
    logic [7:0] frames [8];
    logic [7:0] cap;
    int f;
    int rf;
    int cycles;
    logic acc;
    logic beat;
    for (int i = 0; i < 8; i++) frames[i] = 8'($urandom);
    f      = 0;
    rf     = 0;
    cycles = 0;
    cap    = '0;
    while (rf < 8 && cycles < 400) begin
      bus.in_valid  = (f < 8);
      bus.in_data   = (f < 8) ? frames[f] : 8'h00;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc  = bus.in_valid && bus.in_ready;
      beat = bus.out_valid && bus.out_ready;
      if (beat) begin
        cap[bus.out_sel] = bus.out_data;
        if (bus.out_sel == 3'd7) begin
          checks++; if (cap !== frames[rf]) begin errors++; $display("FAIL rt_frame[%0d]: got %h want %h", rf, cap, frames[rf]); end
          rf++;
        end
      end
      if (acc) f++;
      @(posedge clk);
      #1;
      cycles++;
    end
    checks++; if (rf != 8) begin errors++; $display("FAIL rt_timeout: got %0d frames want 8", rf); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
